gpu_text_ctrl: RTL and testbench
================================

# gpu_text_ctrl

Parametrised text-mode command controller for the GPU: accepts a two-word opcode/parameter stream from the CPU over a valid/ready handshake and maintains a COLS×ROWS character buffer with cursor tracking. It adds hardware clear and scroll sequencers that run one cell per clock. It sits between the CPU bus and the VGA text pipeline; the display timing/font path reads the buffer through a dedicated registered read port.

## Interface
Parameters:
- COLS, 40, characters per row (≥2)
- ROWS, 25, rows per screen (≥2)
- CHAR_W, 8, bits stored per cell
- ADDR_W, 12, buffer address width; must satisfy 2^ADDR_W ≥ COLS*ROWS

Ports:
- clk  in  1  system clock, all state on rising edge
- clr  in  1  reset, asynchronous, active-low
- cpu_data  in  16  command word (opcode or parameter)
- cpu_valid  in  1  cpu_data valid this cycle
- cpu_ready  out  1  word accepted on a cycle where cpu_valid && cpu_ready
- rd_addr  in  ADDR_W  display read address (row*COLS + col)
- rd_data  out  CHAR_W  registered cell contents for rd_addr
- cur_x  out  ADDR_W  cursor column, 0..COLS-1
- cur_y  out  ADDR_W  cursor row, 0..ROWS-1
- busy  out  1  clear or scroll sweep in progress
- err  out  1  one-cycle pulse on unknown opcode

## Operation
- States: OP (await opcode), PARAM (await parameter), EXEC (one cycle), CLEAR, SCROLL.
- cpu_ready = 1 only in OP and PARAM.
- Opcode word 0x0000 is NOP: consumed alone; state stays OP.
- Any other opcode: latch it, go to PARAM. The next accepted word is the parameter, then go to EXEC.
- 0x00C0 with param 0, and 0x00C5 with any param: enter CLEAR. Cursor is set to (0,0). Any other 0x00C0 param is reserved and behaves as NOP.
- 0x00C1 put char: write param[CHAR_W-1:0] at cur_y*COLS+cur_x, then advance the cursor.
  - At end of row: x=0, y+1.
  - At last cell (COLS-1, ROWS-1): see Configuration.
- 0x00C2 backspace: retreat the cursor (x=0 goes to COLS-1 of row y-1), then write 0 at the new position. At (0,0): no write, cursor unchanged.
- 0x00C3 set row: cur_y = min(param, ROWS-1).
- 0x00C4 set column: cur_x = min(param, COLS-1).
- 0x00C6 newline: x=0, y+1. On the last row: see Configuration.
- Unknown opcode: err pulses in EXEC; no state change.
- CLEAR: write 0 to addresses 0..COLS*ROWS-1, one per cycle, then return to OP.
- SCROLL: copy cell a+COLS to cell a for a=0..(ROWS-1)*COLS-1, then zero the last row, then return to OP. Takes COLS*ROWS cycles.
- Address arithmetic is done in ADDR_W bits. The cursor never leaves its range.

## Timing
- Reset (clr low): state CLEAR, busy=1, cpu_ready=0, cur_x=cur_y=0, err=0, rd_data=0.
- After clr rises, the sweep runs COLS*ROWS cycles, then cpu_ready=1.
- clr asserted mid-sweep or mid-command aborts it; the clear restarts from address 0 after release.
- Parameter accepted at edge N → EXEC in cycle N..N+1. RAM write and cursor update take effect at edge N+1. cpu_ready is 1 from edge N+1 for simple commands.
- Sweeps entered from EXEC: busy rises at edge N+1 and falls at edge N+1+COLS*ROWS, when cpu_ready also returns.
- rd_data = buffer[rd_addr] registered one cycle after rd_addr.
  - Same-cycle write to the same address returns the old data.
  - rd_addr ≥ COLS*ROWS returns 0.
- The read port is never stalled by sweeps.

## Configuration
- GPU_SCROLL_EN defined: put char at the last cell, or newline on the last row, enters SCROLL. The cursor ends at (0, ROWS-1).
- GPU_SCROLL_EN undefined: the same events wrap the cursor to (0,0) with no buffer change. The SCROLL state is not built and busy only reflects CLEAR.

## Test plan
- Release reset → busy=1 for 1000 cycles (40×25), then cpu_ready=1; every rd_addr reads 0.
- Send C1/0x41, C1/0x42 → rd_addr 0 gives 0x41, rd_addr 1 gives 0x42; cursor (2,0).
- Send C4/50, C3/30 → cursor (39,24) via clamping. C1/0x5A writes address 999. With GPU_SCROLL_EN: 1000-cycle busy, cursor (0,24), row 23 equals the old row 24 content. Without it: cursor (0,0).
- At (0,0) send C2/x → no write, cursor unchanged. At (0,1) send C2 → cursor (39,0) and address 39 cleared.
- Send opcode 0x00AB/param 7 → err high exactly one cycle, buffer and cursor unchanged. Then NOP 0x0000 → accepted with no param consumed.
- Assert clr mid-scroll → outputs reach reset values immediately; a full clear follows release.

Source files
------------

// File: rtl/gpu_text_ctrl.sv
// gpu_text_ctrl
//   Text-mode command controller. The CPU streams opcode/parameter word pairs
//   over a valid/ready handshake. The block maintains a COLS x ROWS character
//   buffer and a cursor. Clear and scroll sequencers sweep the buffer at one
//   cell per clock. The display path reads the buffer through a registered port.
//
//   Optional feature macro: GPU_SCROLL_EN
//     defined   - a put-char at the last cell, or a newline on the last row,
//                 scrolls the screen up one row. The cursor ends at (0, ROWS-1).
//     undefined - the same events wrap the cursor to (0,0). No SCROLL state
//                 is built.
//
// Ports
//   clk        system clock, rising edge
//   clr        asynchronous active-low reset
//   cpu_data   command word (opcode or parameter)
//   cpu_valid  cpu_data valid
//   cpu_ready  word accepted when cpu_valid && cpu_ready
//   rd_addr    display read address (row*COLS + col)
//   rd_data    registered buffer contents for rd_addr (0 when out of range)
//   cur_x      cursor column
//   cur_y      cursor row
//   busy       clear/scroll sweep in progress
//   err        one-cycle pulse on an unknown opcode
module gpu_text_ctrl #(
    parameter int COLS   = 40,
    parameter int ROWS   = 25,
    parameter int CHAR_W = 8,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [15:0]       cpu_data,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CHAR_W-1:0] rd_data,
    output logic [ADDR_W-1:0] cur_x,
    output logic [ADDR_W-1:0] cur_y,
    output logic              busy,
    output logic              err
);

    localparam int CELLS = COLS * ROWS;
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

    localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_X = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_Y = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(CELLS - 1);
`ifdef GPU_SCROLL_EN
    localparam logic [ADDR_W-1:0] COPY_END = ADDR_W'((ROWS - 1) * COLS);
`endif

    localparam logic [15:0] OP_NOP   = 16'h0000;
    localparam logic [15:0] OP_CLR   = 16'h00C0;
    localparam logic [15:0] OP_PUT   = 16'h00C1;
    localparam logic [15:0] OP_BS    = 16'h00C2;
    localparam logic [15:0] OP_ROW   = 16'h00C3;
    localparam logic [15:0] OP_COL   = 16'h00C4;
    localparam logic [15:0] OP_CLR2  = 16'h00C5;
    localparam logic [15:0] OP_NL    = 16'h00C6;

    typedef enum logic [2:0] {
        ST_OP,
        ST_PARAM,
        ST_EXEC,
        ST_CLEAR
`ifdef GPU_SCROLL_EN
        , ST_SCROLL
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         opcode_q, opcode_d;
    logic [15:0]         param_q, param_d;
    logic [ADDR_W-1:0]   cur_x_q, cur_x_d;
    logic [ADDR_W-1:0]   cur_y_q, cur_y_d;
    logic [ADDR_W-1:0]   sweep_q, sweep_d;
    logic                err_q, err_d;
    logic [CHAR_W-1:0]   rd_data_q;

    logic [CHAR_W-1:0]   mem [CELLS];
    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [CHAR_W-1:0]   wdata;
    logic [ADDR_W-1:0]   cur_addr;
`ifdef GPU_SCROLL_EN
    logic [ADDR_W-1:0]   scroll_src;
    assign scroll_src = sweep_q + COLS_A;
`endif

    assign cur_addr = cur_y_q * COLS_A + cur_x_q;

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        param_d  = param_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        sweep_d  = sweep_q;
        err_d    = 1'b0;
        we       = 1'b0;
        waddr    = sweep_q;
        wdata    = '0;

        case (state_q)
            ST_OP: begin
                // A zero opcode is a NOP and never consumes a parameter word.
                if (cpu_valid && (cpu_data != OP_NOP)) begin
                    opcode_d = cpu_data;
                    state_d  = ST_PARAM;
                end
            end
            ST_PARAM: begin
                if (cpu_valid) begin
                    param_d = cpu_data;
                    state_d = ST_EXEC;
                    // Raised here so the pulse coincides with the EXEC cycle.
                    err_d   = !(opcode_q inside {OP_CLR, OP_PUT, OP_BS, OP_ROW,
                                                 OP_COL, OP_CLR2, OP_NL});
                end
            end
            ST_EXEC: begin
                state_d = ST_OP;
                case (opcode_q)
                    OP_CLR, OP_CLR2: begin
                        // Any C0 parameter other than zero is reserved (NOP).
                        if ((opcode_q == OP_CLR2) || (param_q == 16'h0000)) begin
                            cur_x_d = '0;
                            cur_y_d = '0;
                            sweep_d = '0;
                            state_d = ST_CLEAR;
                        end
                    end
                    OP_PUT: begin
                        we    = 1'b1;
                        waddr = cur_addr;
                        wdata = param_q[CHAR_W-1:0];
                        if (cur_x_q != LAST_X) begin
                            cur_x_d = cur_x_q + ADDR_W'(1);
                        end else if (cur_y_q != LAST_Y) begin
                            cur_x_d = '0;
                            cur_y_d = cur_y_q + ADDR_W'(1);
                        end else begin
`ifdef GPU_SCROLL_EN
                            cur_x_d = '0;
                            cur_y_d = LAST_Y;
                            sweep_d = '0;
                            state_d = ST_SCROLL;
`else
                            cur_x_d = '0;
                            cur_y_d = '0;
`endif
                        end
                    end
                    OP_BS: begin
                        if ((cur_x_q != '0) || (cur_y_q != '0)) begin
                            // The retreated position is always the previous linear address.
                            we    = 1'b1;
                            waddr = cur_addr - ADDR_W'(1);
                            if (cur_x_q == '0) begin
                                cur_x_d = LAST_X;
                                cur_y_d = cur_y_q - ADDR_W'(1);
                            end else begin
                                cur_x_d = cur_x_q - ADDR_W'(1);
                            end
                        end
                    end
                    OP_ROW: cur_y_d = (param_q >= 16'(ROWS - 1)) ? LAST_Y : ADDR_W'(param_q);
                    OP_COL: cur_x_d = (param_q >= 16'(COLS - 1)) ? LAST_X : ADDR_W'(param_q);
                    OP_NL: begin
                        cur_x_d = '0;
                        if (cur_y_q != LAST_Y) begin
                            cur_y_d = cur_y_q + ADDR_W'(1);
                        end else begin
`ifdef GPU_SCROLL_EN
                            cur_y_d = LAST_Y;
                            sweep_d = '0;
                            state_d = ST_SCROLL;
`else
                            cur_y_d = '0;
`endif
                        end
                    end
                    default: ;
                endcase
            end
            ST_CLEAR: begin
                we      = 1'b1;
                waddr   = sweep_q;
                sweep_d = sweep_q + ADDR_W'(1);
                if (sweep_q == LAST_A) begin
                    sweep_d = '0;
                    state_d = ST_OP;
                end
            end
`ifdef GPU_SCROLL_EN
            ST_SCROLL: begin
                // Rows 0..ROWS-2 take the row below; the last row is zeroed.
                we      = 1'b1;
                waddr   = sweep_q;
                if (sweep_q < COPY_END) begin
                    wdata = mem[scroll_src[IDX_W-1:0]];
                end
                sweep_d = sweep_q + ADDR_W'(1);
                if (sweep_q == LAST_A) begin
                    sweep_d = '0;
                    state_d = ST_OP;
                end
            end
`endif
            default: state_d = ST_OP;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_CLEAR;
            cur_x_q <= '0;
            cur_y_q <= '0;
            sweep_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            sweep_q <= sweep_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        opcode_q <= opcode_d;
        param_q  <= param_d;
        if (we) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    // Display read port; reads before a same-edge write return the old cell.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rd_data_q <= '0;
        end else if (32'(rd_addr) < 32'(CELLS)) begin
            rd_data_q <= mem[rd_addr[IDX_W-1:0]];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign cpu_ready = (state_q == ST_OP) || (state_q == ST_PARAM);
`ifdef GPU_SCROLL_EN
    assign busy      = (state_q == ST_CLEAR) || (state_q == ST_SCROLL);
`else
    assign busy      = (state_q == ST_CLEAR);
`endif
    assign err       = err_q;
    assign rd_data   = rd_data_q;
    assign cur_x     = cur_x_q;
    assign cur_y     = cur_y_q;

endmodule

// File: tb/tb_gpu_text_ctrl.sv
// Testbench for gpu_text_ctrl. Directed command sequences; expected values
// are queued by the stimulus and compared by a separate monitor process.
module tb_gpu_text_ctrl;
    localparam int COLS   = 40;
    localparam int ROWS   = 25;
    localparam int CHAR_W = 8;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              clr = 1'b0;
    logic [15:0]       cpu_data = '0;
    logic              cpu_valid = 1'b0;
    logic              cpu_ready;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [CHAR_W-1:0] rd_data;
    logic [ADDR_W-1:0] cur_x;
    logic [ADDR_W-1:0] cur_y;
    logic              busy;
    logic              err;

    gpu_text_ctrl #(.COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .clr(clr), .cpu_data(cpu_data), .cpu_valid(cpu_valid),
        .cpu_ready(cpu_ready), .rd_addr(rd_addr), .rd_data(rd_data),
        .cur_x(cur_x), .cur_y(cur_y), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int err_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard
    typedef enum int {K_RD, K_X, K_Y, K_BUSY, K_RDY} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] exp;
        string       name;
    } item_t;

    item_t sb[$];
    logic  req = 1'b0;
    logic  req_p1 = 1'b0;

    always @(posedge clk) req_p1 <= req;
    always @(negedge clk) if (err) err_cycles++;

    always @(negedge clk) begin
        item_t       it;
        logic [31:0] act;
        if (req_p1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got empty queue expected an entry");
            end else begin
                it = sb.pop_front();
                case (it.kind)
                    K_RD:    act = 32'(rd_data);
                    K_X:     act = 32'(cur_x);
                    K_Y:     act = 32'(cur_y);
                    K_BUSY:  act = 32'(busy);
                    default: act = 32'(cpu_ready);
                endcase
                check(it.name, act, it.exp);
            end
        end
    end

    task automatic exp_chk(input kind_t kind, input int addr, input int exp, input string name);
        item_t it;
        @(negedge clk);
        rd_addr = ADDR_W'(addr);
        it.kind = kind;
        it.exp  = 32'(exp);
        it.name = name;
        sb.push_back(it);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic exp_cur(input int x, input int y, input string name);
        exp_chk(K_X, 0, x, {name, "_x"});
        exp_chk(K_Y, 0, y, {name, "_y"});
    endtask

    task automatic send(input logic [15:0] w);
        int n;
        n = 0;
        @(negedge clk);
        cpu_data  = w;
        cpu_valid = 1'b1;
        while (!cpu_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!cpu_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no cpu_ready expected ready within 3000 cycles");
            cpu_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            cpu_valid = 1'b0;
        end
    endtask

    task automatic cmd(input logic [15:0] op, input logic [15:0] prm);
        send(op);
        send(prm);
    endtask

    // Called right after a command: n = busy cycles, k = cycles until ready.
    task automatic measure(output int n, output int k);
        n = 0;
        k = 0;
        do begin
            @(negedge clk);
            if (busy) n++;
            k++;
        end while (!cpu_ready && k < 5000);
    endtask

    task automatic reset_check(input string tag);
        int n, k;
        @(negedge clk);
        clr = 1'b0;
        #1;
        check({tag, "_rst_busy"}, 32'(busy), 1);
        check({tag, "_rst_ready"}, 32'(cpu_ready), 0);
        check({tag, "_rst_x"}, 32'(cur_x), 0);
        check({tag, "_rst_y"}, 32'(cur_y), 0);
        check({tag, "_rst_err"}, 32'(err), 0);
        check({tag, "_rst_rd"}, 32'(rd_data), 0);
        repeat (3) @(negedge clk);
        clr = 1'b1;
        measure(n, k);
        check({tag, "_sweep_len"}, 32'(k), 1000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected completion in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, e0, exp0;

        // Reset and initial clear sweep
        reset_check("init");
        exp_chk(K_BUSY, 0, 0, "idle_busy");
        exp_chk(K_RDY, 0, 1, "idle_ready");
        exp_chk(K_RD, 0, 0, "clr_rd0");
        exp_chk(K_RD, 500, 0, "clr_rd500");
        exp_chk(K_RD, 999, 0, "clr_rd999");
        exp_chk(K_RD, 1000, 0, "oor_rd1000");
        exp_chk(K_RD, 4095, 0, "oor_rd4095");

        // Put two characters
        cmd(16'h00C1, 16'h0041);
        cmd(16'h00C1, 16'h0042);
        exp_chk(K_RD, 0, 8'h41, "put_rd0");
        exp_chk(K_RD, 1, 8'h42, "put_rd1");
        exp_cur(2, 0, "put_cur");

        // Clamped positioning, then put at the last cell
        cmd(16'h00C4, 16'd50);
        cmd(16'h00C3, 16'd30);
        exp_cur(39, 24, "clamp");
        cmd(16'h00C1, 16'h005A);
        measure(n, k);
`ifdef GPU_SCROLL_EN
        check("scroll_busy_len", 32'(n), 1000);
        check("scroll_ready_after", 32'(k), 1001);
        exp_cur(0, 24, "scroll_cur");
        exp_chk(K_RD, 959, 8'h5A, "scroll_rd959");
        exp_chk(K_RD, 999, 0, "scroll_rd999");
        exp_chk(K_RD, 0, 0, "scroll_rd0");
        exp0 = 0;
`else
        check("wrap_busy_len", 32'(n), 0);
        check("wrap_ready_after", 32'(k), 1);
        exp_cur(0, 0, "wrap_cur");
        exp_chk(K_RD, 999, 8'h5A, "wrap_rd999");
        exp_chk(K_RD, 0, 8'h41, "wrap_rd0");
        exp0 = 8'h41;
`endif

        // Backspace at origin does nothing
        cmd(16'h00C3, 16'd0);
        cmd(16'h00C4, 16'd0);
        cmd(16'h00C2, 16'h0000);
        exp_cur(0, 0, "bs_origin");
        exp_chk(K_RD, 0, exp0, "bs_origin_rd0");

        // End-of-row advance, then backspace across the row boundary
        cmd(16'h00C4, 16'd39);
        cmd(16'h00C1, 16'h0033);
        exp_cur(0, 1, "eol_cur");
        exp_chk(K_RD, 39, 8'h33, "eol_rd39");
        cmd(16'h00C2, 16'h0000);
        exp_cur(39, 0, "bs_wrap");
        exp_chk(K_RD, 39, 0, "bs_rd39");

        // Unknown opcode
        e0 = err_cycles;
        cmd(16'h00AB, 16'd7);
        repeat (3) @(negedge clk);
        check("err_pulse_len", 32'(err_cycles - e0), 1);
        exp_cur(39, 0, "err_cur");
        exp_chk(K_RD, 0, exp0, "err_rd0");

        // NOP takes no parameter
        send(16'h0000);
        cmd(16'h00C4, 16'd5);
        exp_cur(5, 0, "nop_cur");

        // Newline
        cmd(16'h00C6, 16'h0000);
        exp_cur(0, 1, "nl_cur");

        // Reserved clear parameter behaves as NOP
        cmd(16'h00C1, 16'h0044);
        exp_chk(K_RD, 40, 8'h44, "pre_clr_rd40");
        cmd(16'h00C0, 16'd1);
        measure(n, k);
        check("c0_resv_busy", 32'(n), 0);
        exp_cur(1, 1, "c0_resv_cur");

        // Clear via C0/0 and via C5
        cmd(16'h00C0, 16'd0);
        measure(n, k);
        check("c0_busy_len", 32'(n), 1000);
        check("c0_ready_after", 32'(k), 1001);
        exp_cur(0, 0, "c0_cur");
        exp_chk(K_RD, 40, 0, "c0_rd40");
        cmd(16'h00C1, 16'h0055);
        exp_chk(K_RD, 0, 8'h55, "pre_c5_rd0");
        cmd(16'h00C5, 16'd9);
        measure(n, k);
        check("c5_busy_len", 32'(n), 1000);
        exp_chk(K_RD, 0, 0, "c5_rd0");

        // Reset in the middle of a command
        cmd(16'h00C3, 16'd3);
        cmd(16'h00C4, 16'd8);
        cmd(16'h00C1, 16'h0077);
        exp_cur(9, 3, "pre_abort_cur");
        send(16'h00C1);
        reset_check("mid_cmd");
        exp_chk(K_RD, 128, 0, "mid_cmd_rd128");

        // Reset in the middle of a sweep
`ifdef GPU_SCROLL_EN
        cmd(16'h00C3, 16'd24);
        cmd(16'h00C4, 16'd39);
        cmd(16'h00C1, 16'h0066);
`else
        cmd(16'h00C5, 16'd0);
`endif
        repeat (20) @(negedge clk);
        check("mid_sweep_busy", 32'(busy), 1);
        reset_check("mid_sweep");
        exp_chk(K_RD, 999, 0, "mid_sweep_rd999");
        exp_chk(K_RDY, 0, 1, "mid_sweep_ready");

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
